// File: rtl/viterbi_decision_unit_if.sv
// Handshake bundle between the ACS array, the decision unit and the bit sink.
// Optional best-metric signals exist only when BEST_METRIC_OUT_EN is defined.
interface viterbi_decision_unit_if #(
    parameter int path_width = 4,
    parameter int seq_width  = 10
);
    logic                  in_valid;
    logic [path_width-1:0] pmu00;
    logic [path_width-1:0] pmu01;
    logic [path_width-1:0] pmu10;
    logic [path_width-1:0] pmu11;
    logic [seq_width-1:0]  seq00;
    logic [seq_width-1:0]  seq01;
    logic [seq_width-1:0]  seq10;
    logic [seq_width-1:0]  seq11;
    logic                  busy;
    logic                  overrun;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_bit;
    logic                  frame_done;
`ifdef BEST_METRIC_OUT_EN
    logic [1:0]            best_state;
    logic [path_width-1:0] best_metric;
`endif

    modport master (
        output in_valid, pmu00, pmu01, pmu10, pmu11,
        output seq00, seq01, seq10, seq11, out_ready,
`ifdef BEST_METRIC_OUT_EN
        input  best_state, best_metric,
`endif
        input  busy, overrun, out_valid, out_bit, frame_done
    );

    modport slave (
        input  in_valid, pmu00, pmu01, pmu10, pmu11,
        input  seq00, seq01, seq10, seq11, out_ready,
`ifdef BEST_METRIC_OUT_EN
        output best_state, best_metric,
`endif
        output busy, overrun, out_valid, out_bit, frame_done
    );
endinterface

// File: rtl/viterbi_decision_unit.sv
// Frame-end survivor selection and MSB-first serial output of the winner.
// Define BEST_METRIC_OUT_EN to expose the winning state and its metric.
module viterbi_decision_unit #(
    parameter int path_width = 4,
    parameter int seq_width  = 10,
    parameter int frame_len  = 10
) (
    input  logic clk,
    input  logic reset,
    viterbi_decision_unit_if.slave bus
);
    localparam int step_w = $clog2(frame_len + 1);
    localparam int idx_w  = $clog2(seq_width + 1);

    typedef enum logic [1:0] {COLLECT, SELECT, SHIFT} state_t;

    state_t                state, state_nxt;
    logic [step_w-1:0]     step_cnt;
    logic [idx_w-1:0]      bit_idx;
    logic [path_width-1:0] pm_q  [4];
    logic [seq_width-1:0]  seq_q [4];
    logic [seq_width-1:0]  shift_q;
    logic                  overrun_q;
    logic                  frame_done_q;
    logic                  step_last;
    logic                  accept;
    logic                  last_bit;
    logic [1:0]            win;
    logic [path_width-1:0] win_pm;

    assign step_last = (state == COLLECT) && bus.in_valid
                    && (step_cnt == step_w'(frame_len - 1));
    assign accept    = (state == SHIFT) && bus.out_ready;
    assign last_bit  = (bit_idx == idx_w'(seq_width - 1));

    // Strict less-than keeps the lowest index on ties.
    always_comb begin
        win    = 2'd0;
        win_pm = pm_q[0];
        for (int i = 1; i < 4; i++) begin
            if (pm_q[i] < win_pm) begin
                win    = 2'(i);
                win_pm = pm_q[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= COLLECT;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            COLLECT: if (step_last) state_nxt = SELECT;
            SELECT:  state_nxt = SHIFT;
            SHIFT:   if (accept && last_bit) state_nxt = COLLECT;
            default: state_nxt = COLLECT;
        endcase
    end

    always_comb begin
        bus.busy       = (state != COLLECT);
        bus.out_valid  = (state == SHIFT);
        bus.out_bit    = (state == SHIFT) && shift_q[seq_width-1];
        bus.overrun    = overrun_q;
        bus.frame_done = frame_done_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step_cnt     <= '0;
            bit_idx      <= '0;
            shift_q      <= '0;
            overrun_q    <= 1'b0;
            frame_done_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                pm_q[i]  <= '0;
                seq_q[i] <= '0;
            end
        end else begin
            overrun_q    <= bus.in_valid && (state != COLLECT);
            frame_done_q <= accept && last_bit;
            if ((state == COLLECT) && bus.in_valid) begin
                step_cnt <= step_last ? '0 : step_cnt + 1'b1;
            end
            if (step_last) begin
                pm_q[0]  <= bus.pmu00;
                pm_q[1]  <= bus.pmu01;
                pm_q[2]  <= bus.pmu10;
                pm_q[3]  <= bus.pmu11;
                seq_q[0] <= bus.seq00;
                seq_q[1] <= bus.seq01;
                seq_q[2] <= bus.seq10;
                seq_q[3] <= bus.seq11;
            end
            if (state == SELECT) begin
                shift_q <= seq_q[win];
                bit_idx <= '0;
            end else if (accept) begin
                shift_q <= shift_q << 1;
                bit_idx <= bit_idx + 1'b1;
            end
        end
    end

`ifdef BEST_METRIC_OUT_EN
    logic [1:0]            best_state_q;
    logic [path_width-1:0] best_metric_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            best_state_q  <= '0;
            best_metric_q <= '0;
        end else if (state == SELECT) begin
            best_state_q  <= win;
            best_metric_q <= win_pm;
        end
    end

    assign bus.best_state  = best_state_q;
    assign bus.best_metric = best_metric_q;
`endif
endmodule

// File: tb/tb_viterbi_decision_unit.sv
// Scoreboard bench for viterbi_decision_unit: directed frames, stalls,
// overrun and mid-frame reset.
module tb_viterbi_decision_unit;
    localparam int PW = 4;
    localparam int SW = 10;
    localparam int FL = 10;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    viterbi_decision_unit_if #(.path_width(PW), .seq_width(SW)) bus ();

    viterbi_decision_unit #(
        .path_width(PW), .seq_width(SW), .frame_len(FL)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int   checks = 0;
    int   failures = 0;
    logic exp_q[$];
    int   fd_cnt = 0;
    int   acc_cnt = 0;
    int   valid_cycles = 0;
    int   vcnt = 0;
    bit   toggle_mode = 1'b0;
    logic prev_stall = 1'b0;
    logic prev_bit = 1'b0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted bit.
    always @(negedge clk) begin
        if (!reset) begin
            if (prev_stall)
                check("stall_hold", {30'd0, bus.out_valid, bus.out_bit},
                      {30'd0, 1'b1, prev_bit});
            if (bus.out_valid) valid_cycles++;
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_bit actual=%0b required=none",
                             bus.out_bit);
                end else begin
                    check("bit", {31'd0, bus.out_bit},
                          {31'd0, exp_q.pop_front()});
                end
                acc_cnt++;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_bit   = bus.out_bit;
            if (bus.frame_done) fd_cnt++;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Sink: ready always, or alternating 1,0,1,0 from the first valid cycle.
    always @(posedge clk) begin
        #1;
        if (bus.out_valid) begin
            bus.out_ready = toggle_mode ? (vcnt % 2 == 0) : 1'b1;
            vcnt++;
        end else begin
            vcnt = 0;
            bus.out_ready = 1'b1;
        end
    end

    task automatic send_step(input logic [3:0] p0, p1, p2, p3,
                             input logic [9:0] s0, s1, s2, s3);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.pmu00 = p0; bus.pmu01 = p1; bus.pmu10 = p2; bus.pmu11 = p3;
        bus.seq00 = s0; bus.seq01 = s1; bus.seq10 = s2; bus.seq11 = s3;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic frame(input logic [3:0] p0, p1, p2, p3,
                         input logic [9:0] s0, s1, s2, s3,
                         input logic [9:0] exp_seq, input int pre);
        for (int i = 0; i < pre; i++)
            send_step(4'h0, 4'hF, 4'h0, 4'hF, 10'h3FF, 10'h001,
                      10'h3FF, 10'h001);
        for (int i = SW - 1; i >= 0; i--) exp_q.push_back(exp_seq[i]);
        send_step(p0, p1, p2, p3, s0, s1, s2, s3);
    endtask

    task automatic wait_done(input string name);
        int start;
        start = fd_cnt;
        for (int i = 0; i < 200 && fd_cnt == start; i++) @(posedge clk);
        check(name, fd_cnt - start, 1);
        check({name, "_queue_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        int fd0;
        int a0;
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.pmu00 = '0; bus.pmu01 = '0; bus.pmu10 = '0; bus.pmu11 = '0;
        bus.seq00 = '0; bus.seq01 = '0; bus.seq10 = '0; bus.seq11 = '0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", {31'd0, bus.out_valid}, 0);
        check("rst_busy", {31'd0, bus.busy}, 0);
        check("rst_overrun", {31'd0, bus.overrun}, 0);
        check("rst_frame_done", {31'd0, bus.frame_done}, 0);
        check("rst_out_bit", {31'd0, bus.out_bit}, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // State 01 wins; check SELECT cycle then first valid cycle.
        valid_cycles = 0;
        frame(4'd5, 4'd2, 4'd7, 4'd9, 10'h3FF, 10'b1011001110, 10'h000,
              10'h2AA, 10'b1011001110, FL - 1);
        @(negedge clk);
        check("select_busy", {31'd0, bus.busy}, 1);
        check("select_out_valid", {31'd0, bus.out_valid}, 0);
        @(negedge clk);
        check("shift_out_valid", {31'd0, bus.out_valid}, 1);
        wait_done("f1_done");
        check("f1_cycles", valid_cycles, 10);

        // All-equal metrics: state 00 wins.
        frame(4'd3, 4'd3, 4'd3, 4'd3, 10'h155, 10'h2AA, 10'h3FF, 10'h0F0,
              10'h155, FL - 1);
        wait_done("tie_done");

        // Alternating ready: 10 bits over 19 valid cycles.
        toggle_mode = 1'b1;
        valid_cycles = 0;
        frame(4'd8, 4'd9, 4'd10, 4'd1, 10'h000, 10'h3FF, 10'h111, 10'h2C3,
              10'h2C3, FL - 1);
        wait_done("toggle_done");
        check("toggle_cycles", valid_cycles, 19);
        toggle_mode = 1'b0;

        // in_valid while streaming is ignored and flagged.
        frame(4'd4, 4'd6, 4'd1, 4'd8, 10'h001, 10'h002, 10'h0F3, 10'h004,
              10'h0F3, FL - 1);
        for (int i = 0; i < 20 && !bus.out_valid; i++) @(negedge clk);
        @(posedge clk);
        #1 bus.in_valid = 1'b1;
        bus.pmu00 = 4'd0;
        bus.seq00 = 10'h3FF;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        check("overrun_pulse", {31'd0, bus.overrun}, 1);
        @(negedge clk);
        check("overrun_clear", {31'd0, bus.overrun}, 0);
        wait_done("ovr_done");
        for (int i = 0; i < FL - 1; i++)
            send_step(4'h0, 4'hF, 4'h0, 4'hF, 10'h3FF, 10'h001,
                      10'h3FF, 10'h001);
        repeat (3) @(negedge clk);
        check("ovr_no_early_frame", {31'd0, bus.busy}, 0);
        frame(4'd9, 4'd0, 4'd9, 4'd9, 10'h000, 10'h26B, 10'h3FF, 10'h3FF,
              10'h26B, 0);
        @(negedge clk);
        check("ovr_frame_busy", {31'd0, bus.busy}, 1);
        wait_done("ovr_next_done");

        // Reset after four bits accepted aborts the frame.
        a0 = acc_cnt;
        frame(4'd9, 4'd9, 4'd9, 4'd2, 10'h000, 10'h000, 10'h000, 10'h3A5,
              10'h3A5, FL - 1);
        for (int i = 0; i < 100 && acc_cnt < a0 + 4; i++) @(posedge clk);
        check("rst_mid_bits", acc_cnt - a0, 4);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_out_valid", {31'd0, bus.out_valid}, 0);
        check("rst_mid_busy", {31'd0, bus.busy}, 0);
        exp_q.delete();
        fd0 = fd_cnt;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (5) @(posedge clk);
        check("rst_mid_no_done", fd_cnt - fd0, 0);

        // Equal minimum on 10 and 11: 10 wins.
        frame(4'd15, 4'd14, 4'd1, 4'd1, 10'h0AA, 10'h0BB, 10'h1C7, 10'h3E0,
              10'h1C7, FL - 1);
        wait_done("best_done");
`ifdef BEST_METRIC_OUT_EN
        check("best_state", {30'd0, bus.best_state}, 2);
        check("best_metric", {28'd0, bus.best_metric}, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
